// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver: per-slot anode blanking,
// leading-zero suppression and a per-frame snapshot of the displayed value.
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          lz_en,
    input  logic [4*NUM_DIGITS-1:0]       bcd,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [6:0]                    seg_n,
    output logic                          dp_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_COUNT = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_DIGIT  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        prescaler;
    logic [4*NUM_DIGITS-1:0] bcdSnap;
    logic [NUM_DIGITS-1:0]   dpSnap;
    logic                    lzSnap;
    logic                    snapValid;

    logic [NUM_DIGITS-1:0]   leadZero;
    logic                    higherZero;
    logic [3:0]              curNibble;
    logic                    suppress;
    logic                    lastCount;
    logic                    lastDigit;
    logic                    frameWrap;

    function automatic logic [6:0] decode(input logic [3:0] value);
        case (value)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111110;
        endcase
    endfunction

    // leadZero[i] is set when digit i and every more-significant digit are zero.
    always_comb begin
        // NOTE: both outputs get a value before the loop, so no latch can be inferred.
        higherZero = 1'b1;
        leadZero   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            // NOTE: blocking here on purpose; higherZero is a running AND down the loop.
            higherZero  = higherZero && (bcdSnap[4*i +: 4] == 4'd0);
            leadZero[i] = higherZero;
        end
    end

    assign curNibble = bcdSnap[4*digit_idx +: 4];
    assign suppress  = lzSnap && (digit_idx != '0) && leadZero[digit_idx];
    assign lastCount = (prescaler == LAST_COUNT);
    assign lastDigit = (digit_idx == LAST_DIGIT);
    assign frameWrap = lastCount && lastDigit;

    // Pins are registered from the current slot state, so anodes and segments
    // always move together and the blank window trails the prescaler by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_tick <= 1'b0;
            // NOTE: the snapshot is plain flops rather than a RAM, so it resets with everything else.
            bcdSnap    <= '0;
            dpSnap     <= '0;
            lzSnap     <= 1'b0;
            snapValid  <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            an_n       <= '1;
            if (en) begin
                seg_n <= suppress ? 7'h7F : decode(curNibble);
                dp_n  <= ~dpSnap[digit_idx];
                if (prescaler >= BLANK_COUNT) begin
                    an_n <= ~(NUM_DIGITS'(1) << digit_idx);
                end

                if (lastCount) begin
                    prescaler <= '0;
                    digit_idx <= lastDigit ? '0 : digit_idx + 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end

                frame_tick <= frameWrap;
                if (frameWrap || !snapValid) begin
                    bcdSnap   <= bcd;
                    dpSnap    <= dp_in;
                    lzSnap    <= lz_en;
                    snapValid <= 1'b1;
                end
            end
        end
    end

endmodule
